multicycle_control_unit: RTL and testbench

//  Multi-cycle sequencer for the 16-bit CPU datapath; successor to the single-cycle opcode decoder.

---
 rtl/multicycle_control_unit.sv | 161 ++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control sequencer for the 16-bit CPU datapath.
// Walks FETCH/DECODE/EXEC/MEM/WB, stalls on mem_ready, resolves BNE and flags illegal opcodes.
module multicycle_control_unit #(
    parameter int unsigned OPCODE_W = 3,
    parameter int unsigned ALUOP_W  = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic                zero_i,
    input  logic                mem_ready_i,
    output logic                pc_write_o,
    output logic                ir_write_o,
    output logic                reg_dst_o,
    output logic                alu_src_o,
    output logic                mem_to_reg_o,
    output logic [ALUOP_W-1:0]  alu_op_o,
    output logic                mem_read_o,
    output logic                mem_write_o,
    output logic                reg_write_o,
    output logic                illegal_op_o,
    output logic [2:0]          state_o,
    output logic [CNT_W-1:0]    instret_o
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4
    } state_e;

    localparam logic [2:0] OpR    = 3'b000;
    localparam logic [2:0] OpLw   = 3'b101;
    localparam logic [2:0] OpSw   = 3'b110;
    localparam logic [2:0] OpBne  = 3'b111;

    localparam logic [ALUOP_W-1:0] AluAdd = ALUOP_W'(2'b00);
    localparam logic [ALUOP_W-1:0] AluCmp = ALUOP_W'(2'b01);
    localparam logic [ALUOP_W-1:0] AluR   = ALUOP_W'(2'b10);
    localparam logic [ALUOP_W-1:0] AluImm = ALUOP_W'(2'b11);

    state_e           state_q, state_d;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] instret_q;
    logic             retire;
    logic             opcode_illegal;

    // Any opcode bit above [2] makes the instruction illegal.
    if (OPCODE_W > 3) begin : g_wide_opcode
        assign opcode_illegal = |opcode_i[OPCODE_W-1:3];
    end else begin : g_narrow_opcode
        assign opcode_illegal = 1'b0;
    end

    // Next-state and retire decode.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            StFetch: begin
                if (mem_ready_i) state_d = StDecode;
            end
            StDecode: begin
                state_d = opcode_illegal ? StFetch : StExec;
            end
            StExec: begin
                case (op_q)
                    OpLw, OpSw: state_d = StMem;
                    OpBne: begin
                        state_d = StFetch;
                        retire  = 1'b1;
                    end
                    default: state_d = StWb;
                endcase
            end
            StMem: begin
                if (mem_ready_i) begin
                    if (op_q == OpLw) begin
                        state_d = StWb;
                    end else begin
                        state_d = StFetch;
                        retire  = 1'b1;
                    end
                end
            end
            StWb: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            default: state_d = StFetch;
        endcase
    end

    // Datapath controls from state and latched opcode; all forced low during reset.
    always_comb begin
        pc_write_o   = 1'b0;
        ir_write_o   = 1'b0;
        reg_dst_o    = 1'b0;
        alu_src_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        alu_op_o     = AluAdd;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        reg_write_o  = 1'b0;
        illegal_op_o = 1'b0;
        if (!reset_i) begin
            case (state_q)
                StFetch: begin
                    mem_read_o = 1'b1;
                    pc_write_o = mem_ready_i;
                    ir_write_o = mem_ready_i;
                end
                StDecode: illegal_op_o = opcode_illegal;
                StExec: begin
                    case (op_q)
                        OpR:        alu_op_o = AluR;
                        OpLw, OpSw: alu_src_o = 1'b1;
                        OpBne: begin
                            alu_op_o   = AluCmp;
                            pc_write_o = ~zero_i;
                        end
                        default: begin
                            alu_src_o = 1'b1;
                            alu_op_o  = AluImm;
                        end
                    endcase
                end
                StMem: begin
                    mem_read_o  = (op_q == OpLw);
                    mem_write_o = (op_q != OpLw);
                end
                StWb: begin
                    reg_write_o  = 1'b1;
                    reg_dst_o    = (op_q == OpR);
                    mem_to_reg_o = (op_q == OpLw);
                end
                default: ;
            endcase
        end
    end

    // State, latched opcode and retired-instruction counter.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= StFetch;
            op_q      <= 3'b000;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode) op_q <= opcode_i[2:0];
            if (retire) instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign state_o   = state_q;
    assign instret_o = instret_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit with a 4-bit opcode and a 4-bit retire counter.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, ir_write, reg_dst, alu_src, mem_to_reg;
    logic [1:0] alu_op;
    logic       mem_read, mem_write, reg_write, illegal_op;
    logic [2:0] state;
    logic [3:0] instret;
    logic [10:0] ctl;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [10:0] NONE = 11'h000;
    localparam logic [10:0] PCW  = 11'h400;
    localparam logic [10:0] IRW  = 11'h200;
    localparam logic [10:0] RDST = 11'h100;
    localparam logic [10:0] ASRC = 11'h080;
    localparam logic [10:0] M2R  = 11'h040;
    localparam logic [10:0] AR   = 11'h020;
    localparam logic [10:0] ACMP = 11'h010;
    localparam logic [10:0] AIMM = 11'h030;
    localparam logic [10:0] MRD  = 11'h008;
    localparam logic [10:0] MWR  = 11'h004;
    localparam logic [10:0] RW   = 11'h002;
    localparam logic [10:0] ILL  = 11'h001;
    localparam logic [10:0] FGO  = PCW | IRW | MRD;

    multicycle_control_unit #(
        .OPCODE_W(4),
        .ALUOP_W (2),
        .CNT_W   (4)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .opcode_i    (opcode),
        .zero_i      (zero),
        .mem_ready_i (mem_ready),
        .pc_write_o  (pc_write),
        .ir_write_o  (ir_write),
        .reg_dst_o   (reg_dst),
        .alu_src_o   (alu_src),
        .mem_to_reg_o(mem_to_reg),
        .alu_op_o    (alu_op),
        .mem_read_o  (mem_read),
        .mem_write_o (mem_write),
        .reg_write_o (reg_write),
        .illegal_op_o(illegal_op),
        .state_o     (state),
        .instret_o   (instret)
    );

    always #5 clk = ~clk;

    assign ctl = {pc_write, ir_write, reg_dst, alu_src, mem_to_reg, alu_op,
                  mem_read, mem_write, reg_write, illegal_op};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs were set at the falling edge; check settled outputs, then move to the next one.
    task automatic cyc(input string tag, input logic [2:0] st, input logic [10:0] c,
                       input logic [3:0] cnt);
        #1;
        chk({tag, ".state"}, 16'(state), 16'(st));
        chk({tag, ".ctl"}, 16'(ctl), 16'(c));
        chk({tag, ".instret"}, 16'(instret), 16'(cnt));
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = 4'b0000;
        zero      = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        cyc("rst0", 3'd0, NONE, 4'd0);
        cyc("rst1", 3'd0, NONE, 4'd0);

        // T1: two R-type instructions
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc("t1.fetch", 3'd0, FGO, 4'(i));
            cyc("t1.decode", 3'd1, NONE, 4'(i));
            cyc("t1.exec", 3'd2, AR, 4'(i));
            cyc("t1.wb", 3'd4, RW | RDST, 4'(i));
        end

        // T2: LW with three stall cycles in MEM; opcode change after DECODE is ignored
        opcode = 4'b0101;
        cyc("t2.fetch", 3'd0, FGO, 4'd2);
        cyc("t2.decode", 3'd1, NONE, 4'd2);
        opcode    = 4'b0000;
        cyc("t2.exec", 3'd2, ASRC, 4'd2);
        mem_ready = 1'b0;
        cyc("t2.mem_wait0", 3'd3, MRD, 4'd2);
        cyc("t2.mem_wait1", 3'd3, MRD, 4'd2);
        cyc("t2.mem_wait2", 3'd3, MRD, 4'd2);
        mem_ready = 1'b1;
        cyc("t2.mem_done", 3'd3, MRD, 4'd2);
        cyc("t2.wb", 3'd4, RW | M2R, 4'd2);

        // T3: BNE taken (zero=0) then not taken (zero=1)
        opcode = 4'b0111;
        cyc("t3.fetch_a", 3'd0, FGO, 4'd3);
        cyc("t3.decode_a", 3'd1, NONE, 4'd3);
        cyc("t3.exec_taken", 3'd2, ACMP | PCW, 4'd3);
        cyc("t3.fetch_b", 3'd0, FGO, 4'd4);
        cyc("t3.decode_b", 3'd1, NONE, 4'd4);
        zero = 1'b1;
        cyc("t3.exec_not_taken", 3'd2, ACMP, 4'd4);

        // Fetch stall: mem_read held, no IR/PC load, state holds
        mem_ready = 1'b0;
        cyc("fetch_stall", 3'd0, MRD, 4'd5);
        mem_ready = 1'b1;

        // T4: illegal opcode 1011
        opcode = 4'b1011;
        cyc("t4.fetch", 3'd0, FGO, 4'd5);
        cyc("t4.decode_ill", 3'd1, ILL, 4'd5);
        opcode = 4'b0110;
        cyc("t4.back_to_fetch", 3'd0, FGO, 4'd5);

        // T5: SW interrupted by reset while stalled in MEM
        cyc("t5.decode", 3'd1, NONE, 4'd5);
        cyc("t5.exec", 3'd2, ASRC, 4'd5);
        mem_ready = 1'b0;
        cyc("t5.mem_wait", 3'd3, MWR, 4'd5);
        reset = 1'b1;
        cyc("t5.mem_reset", 3'd3, NONE, 4'd5);
        reset     = 1'b0;
        mem_ready = 1'b1;
        cyc("t5.refetch", 3'd0, FGO, 4'd0);

        // T6: 16 immediate-type instructions wrap the 4-bit counter
        for (int i = 0; i < 16; i++) begin
            opcode = 4'(1 + (i % 4));
            if (i != 0) cyc("t6.fetch", 3'd0, FGO, 4'(i));
            cyc("t6.decode", 3'd1, NONE, 4'(i));
            cyc("t6.exec", 3'd2, ASRC | AIMM, 4'(i));
            cyc("t6.wb", 3'd4, RW, 4'(i));
        end
        cyc("t6.wrapped", 3'd0, FGO, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
